hs_bridge_4ph: RTL and testbench



---
 rtl/hs_bridge_4ph_if.sv | 27 ++
 rtl/hs_bridge_4ph.sv | 146 ++++++++++++++
 tb/tb_hs_bridge_4ph.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_bridge_4ph_if.sv
// Bundle of the clocked valid/ready streams and the 4-phase bundled-data channel
// between the bridge ("master" side) and its environment ("slave" side).
interface hs_bridge_4ph_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             req;
   logic [WIDTH-1:0] req_data;
   logic             ack;
   logic [WIDTH-1:0] resp_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             timeout_err;

   modport master (
      input  in_valid, in_data, ack, resp_data, out_ready,
      output in_ready, req, req_data, out_valid, out_data, timeout_err
   );

   modport slave (
      output in_valid, in_data, ack, resp_data, out_ready,
      input  in_ready, req, req_data, out_valid, out_data, timeout_err
   );
endinterface

// File: rtl/hs_bridge_4ph.sv
// Clocked valid/ready to 4-phase bundled-data request bridge with a synchronized
// acknowledge, one-entry result register and sticky per-phase handshake timeout.
module hs_bridge_4ph #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic clk,
   input  logic rst,
   hs_bridge_4ph_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT_HI,
      S_WAIT_LO,
      S_ERROR
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_req;
   logic [WIDTH-1:0]       r_req_data;
   logic                   r_out_valid;
   logic [WIDTH-1:0]       r_out_data;
   logic                   r_timeout_err;

   logic w_ack_s;
   logic w_in_ready;
   logic w_accept;
   logic w_capture;
   logic w_req_set;
   logic w_req_clr;
   logic w_cnt_clr;
   logic w_cnt_inc;
   logic w_set_err;
   logic w_cnt_last;

   assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];
   // Gated by rst so nothing is offered upstream while the bridge is held in reset.
   assign w_in_ready = !rst && (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ack_sync <= '0;
      end else begin
         r_state    <= w_next;
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.ack};
      end
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_req_set = 1'b0;
      w_req_clr = 1'b0;
      w_cnt_clr = 1'b0;
      w_cnt_inc = 1'b0;
      w_set_err = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_SETUP;
         end
         S_SETUP: begin
            w_req_set = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (w_ack_s) begin
               w_capture = 1'b1;
               w_req_clr = 1'b1;
               w_cnt_clr = 1'b1;
               w_next    = S_WAIT_LO;
            end else if (w_cnt_last) begin
               w_req_clr = 1'b1;
               w_set_err = 1'b1;
               w_next    = S_ERROR;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_WAIT_LO: begin
            if (!w_ack_s) begin
               w_next = S_IDLE;
            end else if (w_cnt_last) begin
               w_req_clr = 1'b1;
               w_set_err = 1'b1;
               w_next    = S_ERROR;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_ERROR: begin
            w_req_clr = 1'b1;
            w_set_err = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt         <= '0;
         r_req         <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
         if (w_req_clr)      r_req <= 1'b0;
         else if (w_req_set) r_req <= 1'b1;
         if (w_set_err)      r_timeout_err <= 1'b1;
      end
   end

   // A capture on the same edge as a downstream transfer keeps the register full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_data  <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) r_req_data <= bus.in_data;
         if (w_capture) begin
            r_out_data  <= bus.resp_data;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.req         = r_req;
   assign bus.req_data    = r_req_data;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_data    = r_out_data;
   assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_hs_bridge_4ph.sv
// Scoreboard bench for hs_bridge_4ph: loopback, matched-delay chain, backpressure,
// timeout and reset-in-flight scenarios against a queue-based reference.
`timescale 1ns/1ps
module tb_hs_bridge_4ph;
  localparam int W  = 32;
  localparam int SS = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hs_bridge_4ph_if #(.WIDTH(W)) bus();
  hs_bridge_4ph #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ack source: 0 = zero-delay loopback, 1 = 12x5ns delay chain, 2 = tied low, 3 = manual
  int   ack_mode = 0;
  logic ack_man  = 1'b0;
  logic [12:0] dchain;
  assign dchain[0] = bus.req;
  for (genvar g = 0; g < 12; g++) begin : g_dly
    assign #5 dchain[g+1] = dchain[g];
  end
  assign bus.ack = (ack_mode == 0) ? bus.req :
                   (ack_mode == 1) ? dchain[12] :
                   (ack_mode == 2) ? 1'b0 : ack_man;
  assign bus.resp_data = ~bus.req_data;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents a word and waits for acceptance; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] d, input int budget);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    for (int i = 0; i < budget && !bus.in_ready; i++) begin
      @(negedge clk);
      #1;
    end
    if (!bus.in_ready) begin
      bound_fail("send_accept");
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(~d);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drained(input int budget);
    int i;
    for (i = 0; i < budget && (exp_q.size() != 0 || !bus.in_ready); i++) tick();
    if (i == budget) bound_fail("wait_drained");
  endtask

  // Output monitor and bundled-data stability check, sampled just before each rising edge.
  logic [W-1:0] prev_rd = '0;
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h with no word outstanding", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e);
        end
      end
      if (bus.req) check("req_data_stable", bus.req_data, prev_rd);
      prev_rd = bus.req_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_00A5;
    bus.out_ready = 1'b1;
    rst = 1'b1;

    // Reset held for three cycles with a word offered
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_req", bus.req, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_timeout_err", bus.timeout_err, 0);
      check("rst_req_data", bus.req_data, 0);
      check("rst_out_data", bus.out_data, 0);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Zero-delay loopback, cycle-exact latency relative to accept edge N
    send(32'h0000_00A5, 4);
    check("lb_req_N", bus.req, 0);
    tick(); check("lb_req_N1", bus.req, 1);
    tick(); tick(); check("lb_out_valid_N3", bus.out_valid, 0);
    tick(); check("lb_out_valid_N4", bus.out_valid, 1);
    check("lb_out_data_N4", bus.out_data, 32'hFFFF_FF5A);
    check("lb_req_N4", bus.req, 0);
    tick(); check("lb_out_valid_N5", bus.out_valid, 0);
    tick(); check("lb_in_ready_N6", bus.in_ready, 0);
    tick(); check("lb_in_ready_N7", bus.in_ready, 1);
    send(32'h1234_5678, 2);
    wait_drained(50);

    // Matched delay chain, back-to-back words
    ack_mode = 1;
    for (int k = 1; k <= 3; k++) send(W'(k), 100);
    wait_drained(200);
    for (int k = 0; k < 20; k++) tick();

    // Random words through the loopback
    ack_mode = 0;
    for (int k = 0; k < 6; k++) send($urandom, 20);
    wait_drained(100);

    // Backpressure: second word must wait until the first result drains
    bus.out_ready = 1'b0;
    send(32'hCAFE_0001, 20);
    for (i = 0; i < 20 && !bus.out_valid; i++) tick();
    if (i == 20) bound_fail("bp_first_result");
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hCAFE_0002;
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      check("bp_in_ready_held", bus.in_ready, 0);
      check("bp_req_idle", bus.req, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", bus.in_ready, 1);
    exp_q.push_back(~32'hCAFE_0002);
    tick();
    bus.in_valid = 1'b0;
    check("bp_out_valid_drop", bus.out_valid, 0);
    tick(); check("bp_second_req", bus.req, 1);
    wait_drained(50);

    // Timeout with ack tied low
    ack_mode = 2;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    #1;
    check("to_in_ready", bus.in_ready, 1);
    tick();
    for (int k = 1; k < TO + 1; k++) begin
      tick();
      check("to_req_pending", bus.req, 1);
      check("to_err_pending", bus.timeout_err, 0);
    end
    tick();
    check("to_err_set", bus.timeout_err, 1);
    check("to_req_dropped", bus.req, 0);
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      check("to_in_ready_stuck", bus.in_ready, 0);
      check("to_err_sticky", bus.timeout_err, 1);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("to_err_cleared", bus.timeout_err, 0);
    tick();
    rst = 1'b0;
    tick();

    // Reset while waiting for ack to return low
    ack_mode = 3;
    ack_man  = 1'b0;
    bus.out_ready = 1'b0;
    send(32'h5555_AAAA, 4);
    for (i = 0; i < 10 && !bus.req; i++) tick();
    if (i == 10) bound_fail("rm_req_rise");
    ack_man = 1'b1;
    for (i = 0; i < 10 && !bus.out_valid; i++) tick();
    if (i == 10) bound_fail("rm_capture");
    tick();
    check("rm_req_low_wait_lo", bus.req, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rm_req", bus.req, 0);
    check("rm_out_valid", bus.out_valid, 0);
    check("rm_out_data", bus.out_data, 0);
    check("rm_req_data", bus.req_data, 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      check("rm_no_out_valid", bus.out_valid, 0);
      check("rm_no_req", bus.req, 0);
      check("rm_in_ready", bus.in_ready, 1);
    end
    ack_man = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();

    check("queue_empty", W'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
